// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P7 pipeline: SR/Cause/EPC/PRId state, interrupt/exception request, ERET and mtc0/mfc0.
// Optional BadVAddr (register 8) is built when CP0_BADVADDR_EN is defined.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic [31:0] badvaddr_m,
  input  logic        eret_m,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 6;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = 5;

  localparam logic [AW-1:0] REG_BADVADDR = AW'(8);
  localparam logic [AW-1:0] REG_SR       = AW'(12);
  localparam logic [AW-1:0] REG_CAUSE    = AW'(13);
  localparam logic [AW-1:0] REG_EPC      = AW'(14);
  localparam logic [AW-1:0] REG_PRID     = AW'(15);

  localparam logic [CW-1:0] EXC_ADEL = CW'(4);
  localparam logic [CW-1:0] EXC_ADES = CW'(5);

  logic [HW-1:0] im_q;
  logic          exl_q;
  logic          ie_q;
  logic          bd_q;
  logic [HW-1:0] ip_q;
  logic [CW-1:0] exccode_q;
  logic [DW-1:0] epc_q;
  logic [DW-1:0] badvaddr_rd;

  logic          int_req;
  logic          exc_req;
  logic [DW-1:0] epc_next;

  // Any request is masked while the handler runs (EXL set)
  assign int_req  = (|(hwint & im_q)) & ie_q & ~exl_q;
  assign exc_req  = (exccode_m != CW'(0)) & ~exl_q;
  assign req      = (int_req | exc_req) & ~reset;
  assign epc_next = bd_m ? (pc_m - DW'(4)) : pc_m;
  assign epc_out  = epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      ip_q <= hwint;
      if (req) begin
        exl_q     <= 1'b1;
        exccode_q <= int_req ? CW'(0) : exccode_m;
        bd_q      <= bd_m;
        epc_q     <= epc_next;
      end else begin
        if (eret_m) begin
          exl_q <= 1'b0;
        end
        // Placed after the ERET clear so an mtc0 to SR overrides it
        if (we) begin
          case (addr)
            REG_SR: begin
              im_q  <= wdata[15:10];
              exl_q <= wdata[1];
              ie_q  <= wdata[0];
            end
            REG_EPC: epc_q <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [DW-1:0] badvaddr_q;

  // Captured only for address-error exceptions actually taken
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= '0;
    end else if (req && !int_req && (exccode_m == EXC_ADEL || exccode_m == EXC_ADES)) begin
      badvaddr_q <= badvaddr_m;
    end
  end

  assign badvaddr_rd = badvaddr_q;
`else
  logic unused_badvaddr;

  assign unused_badvaddr = (^badvaddr_m) ^ (^EXC_ADEL) ^ (^EXC_ADES);
  assign badvaddr_rd     = '0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      REG_BADVADDR: rdata = badvaddr_rd;
      REG_SR:       rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
      REG_CAUSE:    rdata = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: expectations are queued as stimulus is applied and popped when outputs are sampled.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  hwint = '0;
  logic [31:0] pc_m = '0;
  logic        bd_m = 1'b0;
  logic [4:0]  exccode_m = '0;
  logic [31:0] badvaddr_m = '0;
  logic        eret_m = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .hwint      (hwint),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exccode_m  (exccode_m),
    .badvaddr_m (badvaddr_m),
    .eret_m     (eret_m),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .epc_out    (epc_out),
    .req        (req)
  );

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %h required <none>", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a);
    addr = a;
    #1;
    cmp(rdata);
  endtask

  task automatic chk_req();
    #1;
    cmp({31'b0, req});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cyc();
    we = 1'b1;
    addr = a;
    wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic idle();
    hwint = '0;
    pc_m = '0;
    bd_m = 1'b0;
    exccode_m = '0;
    badvaddr_m = '0;
    eret_m = 1'b0;
  endtask

  initial begin
    logic [31:0] bva_exp;
`ifdef CP0_BADVADDR_EN
    bva_exp = 32'h0000_3001;
`else
    bva_exp = 32'h0;
`endif

    // Reset with pending interrupt and exception inputs
    cyc();
    hwint = 6'h3f;
    exccode_m = 5'd10;
    expect_val("req_during_reset", 32'd0);
    chk_req();
    cyc();
    expect_val("req_during_reset_2", 32'd0);
    chk_req();
    cyc();
    reset = 1'b0;
    idle();
    expect_val("sr_after_reset", 32'h0);
    expect_val("cause_after_reset", 32'h0);
    expect_val("epc_after_reset", 32'h0);
    expect_val("prid", 32'h0000_0007);
    expect_val("epc_out_after_reset", 32'h0);
    rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd15);
    cmp(epc_out);

    // Timer interrupt
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001;
    pc_m = 32'h0000_3010;
    expect_val("req_timer", 32'd1);
    chk_req();
    cyc();
    idle();
    expect_val("sr_timer", 32'h0000_0403);
    expect_val("cause_timer", 32'h0000_0400);
    expect_val("epc_timer", 32'h0000_3010);
    expect_val("epc_out_timer", 32'h0000_3010);
    rd(5'd12); rd(5'd13); rd(5'd14);
    cmp(epc_out);

    // Exception in a branch delay slot
    mtc0(5'd12, 32'h0);
    exccode_m = 5'd10;
    bd_m = 1'b1;
    pc_m = 32'h0000_3008;
    expect_val("req_delay_slot", 32'd1);
    chk_req();
    cyc();
    idle();
    expect_val("cause_delay_slot", 32'h8000_0028);
    expect_val("epc_delay_slot", 32'h0000_3004);
    expect_val("sr_delay_slot", 32'h0000_0002);
    rd(5'd13); rd(5'd14); rd(5'd12);

    // EXL masks a pending interrupt; ERET releases it
    mtc0(5'd12, 32'h0000_1003);
    hwint = 6'b000100;
    pc_m = 32'h0000_3040;
    expect_val("req_masked_exl", 32'd0);
    chk_req();
    cyc();
    eret_m = 1'b1;
    expect_val("req_masked_on_eret", 32'd0);
    chk_req();
    cyc();
    eret_m = 1'b0;
    expect_val("sr_after_eret", 32'h0000_1001);
    expect_val("req_after_eret", 32'd1);
    rd(5'd12);
    chk_req();
    cyc();
    idle();
    expect_val("cause_ext_int", 32'h0000_1000);
    expect_val("epc_ext_int", 32'h0000_3040);
    expect_val("sr_ext_int", 32'h0000_1003);
    rd(5'd13); rd(5'd14); rd(5'd12);

    // mtc0 to SR overrides a same-cycle ERET
    cyc();
    eret_m = 1'b1;
    we = 1'b1;
    addr = 5'd12;
    wdata = 32'h0000_0003;
    cyc();
    eret_m = 1'b0;
    we = 1'b0;
    expect_val("sr_mtc0_over_eret", 32'h0000_0003);
    rd(5'd12);

    // Request discards a simultaneous mtc0
    mtc0(5'd12, 32'h0);
    we = 1'b1;
    addr = 5'd14;
    wdata = 32'hdead_beec;
    exccode_m = 5'd12;
    pc_m = 32'h0000_3020;
    expect_val("req_with_mtc0", 32'd1);
    chk_req();
    cyc();
    we = 1'b0;
    idle();
    expect_val("epc_mtc0_dropped", 32'h0000_3020);
    expect_val("cause_ov", 32'h0000_0030);
    expect_val("epc_out_ov", 32'h0000_3020);
    rd(5'd14); rd(5'd13);
    cmp(epc_out);

    // Address error captures BadVAddr when built
    mtc0(5'd12, 32'h0);
    exccode_m = 5'd4;
    badvaddr_m = 32'h0000_3001;
    pc_m = 32'h0000_3030;
    expect_val("req_adel", 32'd1);
    chk_req();
    cyc();
    idle();
    expect_val("badvaddr", bva_exp);
    expect_val("cause_adel", 32'h0000_0010);
    expect_val("epc_adel", 32'h0000_3030);
    rd(5'd8); rd(5'd13); rd(5'd14);

    // Writes to read-only and unlisted registers are ignored
    mtc0(5'd15, 32'hffff_ffff);
    mtc0(5'd3, 32'h0000_1234);
    mtc0(5'd8, 32'haaaa_5555);
    mtc0(5'd13, 32'hffff_ffff);
    expect_val("prid_after_write", 32'h0000_0007);
    expect_val("reg3_reads_zero", 32'h0);
    expect_val("badvaddr_readonly", bva_exp);
    expect_val("cause_readonly", 32'h0000_0010);
    rd(5'd15); rd(5'd3); rd(5'd8); rd(5'd13);

    // Reset in the middle of a handler
    cyc();
    reset = 1'b1;
    exccode_m = 5'd10;
    expect_val("req_reset_mid_handler", 32'd0);
    chk_req();
    cyc();
    reset = 1'b0;
    idle();
    expect_val("sr_after_mid_reset", 32'h0);
    expect_val("epc_out_after_mid_reset", 32'h0);
    rd(5'd12);
    cmp(epc_out);

    cyc();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the P7 pipelined CPU. Consumes the 6-bit `HWInt` vector assembled at the top level (timers on bits 0–1, external `interrupt` on bit 2) together with M-stage exception information. Holds the SR, Cause, EPC, PRId and optional BadVAddr registers. Drives the `Req` line that flushes the pipeline and redirects fetch to the handler.

## Interface
- `PRID`, default 32'h0000_0007: constant value returned for register 15.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `hwint` in 6: hardware interrupt lines; bit *i* maps to IP/IM bit 10+*i*.
- `pc_m` in 32: PC of the instruction currently in M.
- `bd_m` in 1: the M instruction sits in a branch delay slot.
- `exccode_m` in 5: M-stage exception code; 0 means no exception.
- `badvaddr_m` in 32: faulting data/instruction address for AdEL/AdES.
- `eret_m` in 1: ERET is in M.
- `we` in 1: mtc0 write enable (M stage).
- `addr` in 5: CP0 register number for mtc0/mfc0.
- `wdata` in 32: mtc0 data.
- `rdata` out 32: mfc0 data, combinational.
- `epc_out` out 32: current EPC, for ERET redirect.
- `req` out 1: take interrupt/exception this cycle, combinational.

## Operation
- **SR (reg 12)**
  - Writable fields: IM = SR[15:10], EXL = SR[1], IE = SR[0].
  - All other bits read 0; writes to them are dropped.
- **Cause (reg 13)**
  - Read-only to software: BD = [31], IP = [15:10], ExcCode = [6:2].
  - Other bits read 0.
- **EPC (reg 14)**: full 32 bits, writable.
- **PRId (reg 15)**: reads `PRID`; writes are ignored.
- **Unlisted registers**: read 0; writes are ignored.
- **Request logic**
  - `int_req = |(hwint & IM) & IE & ~EXL`.
  - `exc_req = (exccode_m != 0) & ~EXL`.
  - `req = (int_req | exc_req) & ~reset`.
  - Interrupt has priority over exception.
- **IP update**: IP <= `hwint` every cycle, unconditionally, including cycles that take a request.
- **On an edge with `req` = 1**
  - EXL <= 1.
  - ExcCode <= 0 if `int_req`, else `exccode_m`.
  - BD <= `bd_m`.
  - EPC <= `bd_m` ? `pc_m` - 4 : `pc_m`. Arithmetic is modulo 2^32.
  - Any same-cycle `we` is discarded.
- **On an edge with `eret_m` = 1 and `req` = 0**: EXL <= 0.
- **mtc0**: with `we` = 1 and `req` = 0, the addressed writable register updates at the edge.
  - The mtc0 takes effect after any same-cycle ERET: an mtc0 to SR wins over ERET's EXL clear.
- **Reads**: `rdata` reflects register state before the edge; there is no write-to-read bypass.

## Timing
- **Reset**: SR, Cause, EPC and BadVAddr are all 0 after the reset edge. Consequently:
  - `req` = 0 (also forced low while `reset` is high);
  - `rdata` = 0 unless `addr` = 15;
  - `epc_out` = 0.
- **`req` latency**: 0 cycles. It is combinational from the inputs plus current state; the top level registers it externally.
- **Register-update latency**: SR/EPC/Cause changes are visible on `rdata`/`epc_out` one cycle after the edge.
- **Nested requests**: while EXL = 1, all requests are masked. A new request fires in the cycle after the ERET edge at the earliest, if its condition still holds.
- **Reset mid-handler**: EXL is cleared and EPC is lost. No request is taken during the reset cycle.

## Configuration
- **`CP0_BADVADDR_EN` defined**
  - Register 8 (BadVAddr) is implemented.
  - On a request edge with `exc_req` taken and `exccode_m` = 4 or 5, BadVAddr <= `badvaddr_m`; otherwise it holds.
  - Read-only to mtc0.
- **`CP0_BADVADDR_EN` undefined**
  - Register 8 reads 0.
  - `badvaddr_m` is ignored (port kept for interface stability).

## Test plan
- **Reset**: assert `reset` with `hwint` = 6'h3f and `exccode_m` = 10 -> `req` = 0. After release, read regs 12/13/14 -> 0, 0, 0; reg 15 -> 32'h0000_0007.
- **Timer interrupt**: mtc0 SR = 32'h0000_0401, then `hwint` = 6'b000001, `pc_m` = 32'h0000_3010 ->
  - `req` = 1 in the same cycle;
  - next cycle: SR = 32'h0000_0403, Cause = 32'h0000_0400, EPC = 32'h0000_3010.
- **Delay-slot exception**: SR = 0, `exccode_m` = 10, `bd_m` = 1, `pc_m` = 32'h0000_3008 -> `req` = 1; then Cause = 32'h8000_0028, EPC = 32'h0000_3004.
- **EXL masking and ERET**
  - With EXL = 1 and `hwint` = 6'b000100 and IM[12] = IE = 1 -> `req` = 0.
  - Pulse `eret_m` -> EXL = 0 next cycle, and `req` = 1 in that cycle.
- **Simultaneous mtc0 and request**: `we` = 1, `addr` = 14, `wdata` = 32'hdead_beec, with `exccode_m` = 12 and `pc_m` = 32'h0000_3020 -> EPC = 32'h0000_3020 and the write is dropped.
- **BadVAddr**: `exccode_m` = 4, `badvaddr_m` = 32'h0000_3001 -> reg 8 reads 32'h0000_3001 with `CP0_BADVADDR_EN` defined, 0 without.
